// File: rtl/usb_rcu_pkg.sv
// Shared types and constants for the USB receiver control unit.
package usb_rcu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 7;

  localparam logic [BYTE_W-1:0] SYNC_BYTE     = 8'h80;
  localparam logic [CNT_W-1:0]  MAX_PKT_BYTES = 7'd66;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    PID_WAIT,
    PID_CHK,
    STORE,
    DATA_WAIT,
    EOP_HOLD,
    DONE,
    ERR_EOP,
    ERR_WAIT,
    ERR_IDLE
  } state_t;

  typedef struct packed {
    logic rcving;
    logic w_enable;
    logic r_error;
    logic pkt_done;
  } rcu_out_t;

  // Moore output decode; used on the next state so the output flops track the state register.
  function automatic rcu_out_t decode_out(input state_t s);
    rcu_out_t o;
    o = '0;
    unique case (s)
      SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT: o.rcving = 1'b1;
      STORE: begin
        o.rcving   = 1'b1;
        o.w_enable = 1'b1;
      end
      ERR_EOP: begin
        o.rcving  = 1'b1;
        o.r_error = 1'b1;
      end
      ERR_WAIT, ERR_IDLE: o.r_error  = 1'b1;
      DONE:               o.pkt_done = 1'b1;
      default:            o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/usb_rcu.sv
// USB receive control unit: tracks sync/PID/data/EOP framing and strobes bytes into the RX FIFO.
module usb_rcu
  import usb_rcu_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_edge,
  input  logic              eop,
  input  logic              shift_enable,
  input  logic              byte_received,
  input  logic [BYTE_W-1:0] rcv_data,
  output logic              rcving,
  output logic              w_enable,
  output logic              r_error,
  output logic              pkt_done
);

  state_t           state;
  state_t           next_state;
  rcu_out_t         out_q;
  logic [CNT_W-1:0] byte_cnt;

  logic eop_bit_c;
  logic pid_ok_c;

  assign eop_bit_c = eop && shift_enable;
  assign pid_ok_c  = (rcv_data[7:4] == ~rcv_data[3:0]);

  // State, byte counter and output flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      out_q    <= '0;
    end else begin
      state <= next_state;
      out_q <= decode_out(next_state);
      if (state == IDLE || state == SYNC_WAIT) begin
        byte_cnt <= '0;
      end else if (state == STORE) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic; eop_bit wins over byte_received in the waiting states
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (d_edge) next_state = SYNC_WAIT;
      SYNC_WAIT: begin
        if (eop_bit_c)          next_state = ERR_WAIT;
        else if (byte_received) next_state = SYNC_CHK;
      end
      SYNC_CHK:  next_state = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR_EOP;
      PID_WAIT:  begin
        if (eop_bit_c)          next_state = ERR_WAIT;
        else if (byte_received) next_state = PID_CHK;
      end
      PID_CHK:   next_state = pid_ok_c ? STORE : ERR_EOP;
      STORE:     next_state = DATA_WAIT;
      DATA_WAIT: begin
        if (eop_bit_c) begin
          next_state = EOP_HOLD;
        end else if (byte_received) begin
          next_state = (byte_cnt < MAX_PKT_BYTES) ? STORE : ERR_EOP;
        end
      end
      EOP_HOLD:  if (d_edge) next_state = DONE;
      DONE:      next_state = IDLE;
      ERR_EOP:   if (eop_bit_c) next_state = ERR_WAIT;
      ERR_WAIT:  if (d_edge) next_state = ERR_IDLE;
      ERR_IDLE:  if (d_edge) next_state = SYNC_WAIT;
      default:   next_state = IDLE;
    endcase
  end

  assign rcving   = out_q.rcving;
  assign w_enable = out_q.w_enable;
  assign r_error  = out_q.r_error;
  assign pkt_done = out_q.pkt_done;

endmodule

// File: tb/tb_usb_rcu.sv
// Self-checking bench for usb_rcu: randomized packets against a packet-level prediction of FIFO writes.
module tb_usb_rcu;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic       pkt_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] wr_q[$];
  int         done_cnt = 0;

  usb_rcu dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .pkt_done     (pkt_done)
  );

  always #5 clk = ~clk;

  // FIFO-side observer: what got written and how many packets completed
  always @(posedge clk) begin
    if (w_enable === 1'b1) wr_q.push_back(rcv_data);
    if (pkt_done === 1'b1) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      eop          = 1'b0;
      shift_enable = noise ? 1'($urandom % 2) : 1'b0;
      d_edge       = noise ? 1'(($urandom % 4) == 0) : 1'b0;
      cyc();
    end
    shift_enable = 1'b0;
    d_edge       = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv_data      = b;
    byte_received = 1'b1;
    cyc();
    byte_received = 1'b0;
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1;
    cyc();
    d_edge = 1'b0;
  endtask

  task automatic send_eop();
    eop          = 1'b1;
    shift_enable = 1'b1;
    cyc();
    eop          = 1'b0;
    shift_enable = 1'b0;
  endtask

  task automatic do_reset();
    d_edge        = 1'b0;
    eop           = 1'b0;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
    rcv_data      = 8'h00;
    n_rst         = 1'b0;
    repeat (2) cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  // One packet: start edge, sync, PID, n_data bytes (last may collide with EOP), EOP, closing edge.
  task automatic run_packet(input string name, input logic [7:0] sync, input logic [7:0] pid,
                            input int n_data, input bit collide);
    logic [7:0] data[$];
    logic [7:0] exp_q[$];
    bit         ok;
    int         stored;
    int         k;
    int         base;
    int         done0;
    bit         exp_we;
    bit         same;

    for (int i = 0; i < n_data; i++) data.push_back(8'($urandom % 256));
    k = collide ? n_data - 1 : n_data;

    // Packet-level prediction: valid framing, at most 66 stored bytes, colliding byte dropped
    ok = (sync == 8'h80) && (pid[7:4] == ~pid[3:0]);
    stored = 0;
    if (ok) begin
      exp_q.push_back(pid);
      stored = 1;
      for (int i = 0; i < k; i++) begin
        if (stored < 66) begin
          exp_q.push_back(data[i]);
          stored++;
        end else begin
          ok = 1'b0;
          break;
        end
      end
    end

    base  = wr_q.size();
    done0 = done_cnt;

    pulse_edge();
    checks++;
    if (rcving !== 1'b1) begin
      errors++;
      $display("FAIL %s start_rcving: got %b want 1", name, rcving);
    end
    idle_gap(3, 1'b1);

    send_byte(sync);
    idle_gap($urandom_range(3, 5), 1'b1);
    checks++;
    if (r_error !== 1'(sync != 8'h80)) begin
      errors++;
      $display("FAIL %s sync_err: got %b want %b", name, r_error, sync != 8'h80);
    end

    send_byte(pid);
    cyc();
    exp_we = (sync == 8'h80) && (pid[7:4] == ~pid[3:0]);
    checks++;
    if (w_enable !== exp_we) begin
      errors++;
      $display("FAIL %s pid_we: got %b want %b", name, w_enable, exp_we);
    end
    idle_gap($urandom_range(2, 4), 1'b1);

    stored = exp_we ? 1 : 0;
    for (int i = 0; i < k; i++) begin
      send_byte(data[i]);
      exp_we = exp_we && (stored < 66);
      if (exp_we) stored++;
      if (exp_we !== w_enable) begin
        checks++;
        errors++;
        $display("FAIL %s data_we[%0d]: got %b want %b", name, i, w_enable, exp_we);
      end else if (i == 0 || i == k - 1) begin
        checks++;
      end
      idle_gap($urandom_range(3, 5), 1'b1);
    end

    if (collide) begin
      rcv_data      = data[n_data-1];
      byte_received = 1'b1;
      eop           = 1'b1;
      shift_enable  = 1'b1;
      cyc();
      byte_received = 1'b0;
      eop           = 1'b0;
      shift_enable  = 1'b0;
      checks++;
      if (w_enable !== 1'b0) begin
        errors++;
        $display("FAIL %s collide_we: got %b want 0", name, w_enable);
      end
    end else begin
      send_eop();
    end
    checks++;
    if (rcving !== 1'b0 || r_error !== !ok) begin
      errors++;
      $display("FAIL %s after_eop: rcving=%b r_error=%b want 0/%b", name, rcving, r_error, !ok);
    end
    idle_gap(2, 1'b0);

    pulse_edge();
    checks++;
    if (pkt_done !== ok || r_error !== !ok) begin
      errors++;
      $display("FAIL %s close: pkt_done=%b r_error=%b want %b/%b", name, pkt_done, r_error, ok, !ok);
    end
    cyc();
    checks++;
    if (pkt_done !== 1'b0 || rcving !== 1'b0) begin
      errors++;
      $display("FAIL %s settle: pkt_done=%b rcving=%b want 0/0", name, pkt_done, rcving);
    end

    same = (wr_q.size() - base) == exp_q.size();
    for (int i = 0; same && i < exp_q.size(); i++) same = (wr_q[base+i] === exp_q[i]);
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL %s fifo_writes: got %0d bytes want %0d", name, wr_q.size() - base, exp_q.size());
    end
    checks++;
    if (done_cnt - done0 != int'(ok)) begin
      errors++;
      $display("FAIL %s pkt_done_count: got %0d want %0d", name, done_cnt - done0, int'(ok));
    end
  endtask

  task automatic check_rearm(input string name);
    pulse_edge();
    checks++;
    if (r_error !== 1'b0 || rcving !== 1'b1) begin
      errors++;
      $display("FAIL %s rearm: r_error=%b rcving=%b want 0/1", name, r_error, rcving);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    #3;
    checks++;
    if ({rcving, w_enable, r_error, pkt_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000", {rcving, w_enable, r_error, pkt_done});
    end
    do_reset();
    checks++;
    if ({rcving, w_enable, r_error, pkt_done} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_outputs: got %b want 0000", {rcving, w_enable, r_error, pkt_done});
    end
  endtask

  task automatic test_good();
    run_packet("good", 8'h80, 8'hC3, 2, 1'b0);
  endtask

  task automatic test_bad_sync();
    run_packet("bad_sync", 8'h81, 8'hC3, 2, 1'b0);
    check_rearm("bad_sync");
    do_reset();
  endtask

  task automatic test_bad_pid();
    run_packet("bad_pid", 8'h80, 8'hC4, 3, 1'b0);
    check_rearm("bad_pid");
    do_reset();
  endtask

  task automatic test_max_len();
    run_packet("max_ok", 8'h80, 8'h5A, 65, 1'b0);
    run_packet("overflow", 8'h80, 8'hE1, 66, 1'b0);
    do_reset();
  endtask

  task automatic test_collide();
    run_packet("collide", 8'h80, 8'h96, 3, 1'b1);
  endtask

  task automatic test_reset_mid_packet();
    pulse_edge();
    idle_gap(3, 1'b0);
    send_byte(8'h80);
    idle_gap(3, 1'b0);
    send_byte(8'hD2);
    idle_gap(3, 1'b0);
    send_byte(8'h11);
    idle_gap(3, 1'b0);
    checks++;
    if (rcving !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: rcving=%b want 1", rcving);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rcving, w_enable, r_error, pkt_done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: got %b want 0000", {rcving, w_enable, r_error, pkt_done});
    end
    cyc();
    n_rst = 1'b1;
    cyc();
    // No fresh edge: bytes and EOP must not start a packet
    send_byte(8'h80);
    idle_gap(3, 1'b0);
    send_eop();
    checks++;
    if (rcving !== 1'b0 || r_error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_need_edge: rcving=%b r_error=%b want 0/0", rcving, r_error);
    end
    run_packet("after_reset", 8'h80, 8'hC3, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] sync;
    logic [7:0] pid;
    logic [3:0] nib;
    int         n;
    bit         col;
    for (int it = 0; it < 12; it++) begin
      sync = (($urandom % 5) == 0) ? 8'($urandom % 256) : 8'h80;
      nib  = 4'($urandom % 16);
      pid  = (($urandom % 4) == 0) ? 8'($urandom % 256) : {~nib, nib};
      n    = $urandom_range(0, 70);
      col  = (n > 0) && (($urandom % 2) == 1);
      run_packet($sformatf("rand%0d", it), sync, pid, n, col);
      do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_sync();
    test_bad_pid();
    test_max_len();
    test_collide();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
